// File: rtl/alu_pkg.sv
// Shared funct codes, FSM state encoding and the single/multi-cycle classifier
// for the sequential ALU; no logic, no latency, no flow control.
package alu_pkg;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_CLZ   = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_BGTZ  = 6'b110010;
  localparam logic [5:0] F_B     = 6'b110100;
  localparam logic [5:0] F_BLEZ  = 6'b110110;
  localparam logic [5:0] F_CLO   = 6'b111000;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  typedef enum logic {FC_SINGLE, FC_MULTI} func_class_t;

  function automatic func_class_t func_class(input logic [5:0] f);
    case (f)
      F_MULT, F_MULTU, F_DIV, F_DIVU: return FC_MULTI;
      default:                        return FC_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 magnitude multiply / restoring divide sharing one WIDTH+1 adder;
// one bit per step, WIDTH steps after load; the caller paces it with step.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi_raw,
  output logic [WIDTH-1:0] lo_raw
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             mode_div;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             cin;
  logic [WIDTH+1:0] sum;

  // Divide subtracts via x + ~y + 1; the carry out doubles as "remainder >= divisor".
  always_comb begin
    shifted = {acc, q[WIDTH-1]};
    add_x   = {1'b0, acc};
    add_y   = '0;
    cin     = 1'b0;
    if (mode_div) begin
      add_x = shifted;
      add_y = ~{1'b0, m};
      cin   = 1'b1;
    end else if (q[0]) begin
      add_y = {1'b0, m};
    end
    sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      mode_div <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      q        <= a_mag;
      m        <= b_mag;
      mode_div <= is_div;
    end else if (step) begin
      if (mode_div) begin
        if (sum[WIDTH+1]) begin
          acc <= sum[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= shifted[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= sum[WIDTH:1];
        q   <= {sum[0], q[WIDTH-1:1]};
      end
    end
  end

  assign hi_raw = acc;
  assign lo_raw = q;

endmodule

// File: rtl/alu_seq_hilo.sv
// EX-stage ALU with HI/LO and iterative mul/div: 1 cycle to done for simple ops,
// WIDTH+2 for mul/div; start is ignored while busy, so the control unit stalls on busy.
module alu_seq_hilo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             z_flag,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state, nxt;
  logic [5:0]       func_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  logic             accept, eng_load, eng_step;
  logic             in_signed, in_div;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH-1:0] hi_raw, lo_raw;

  assign accept    = (state == S_IDLE) && start;
  assign in_signed = (func == F_MULT) || (func == F_DIV);
  assign in_div    = (func == F_DIV) || (func == F_DIVU);
  assign a_mag_in  = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag_in  = (in_signed && b[WIDTH-1]) ? -b : b;

  always_comb begin
    nxt      = state;
    eng_load = 1'b0;
    eng_step = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        eng_load = (func_class(func) == FC_MULTI);
        nxt      = (func_class(func) == FC_MULTI) ? S_ITER : S_DONE;
      end
      S_ITER: begin
        eng_step = 1'b1;
        if (cnt == CNT_LAST) nxt = S_FIX;
      end
      S_FIX:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (eng_load),
    .step   (eng_step),
    .is_div (in_div),
    .a_mag  (a_mag_in),
    .b_mag  (b_mag_in),
    .hi_raw (hi_raw),
    .lo_raw (lo_raw)
  );

  // Sign fix-up of the magnitude result, using the operands latched at accept.
  logic               sgn_q, neg_a, neg_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fx_hi, fx_lo;

  always_comb begin
    sgn_q = (func_q == F_MULT) || (func_q == F_DIV);
    neg_a = sgn_q && a_q[WIDTH-1];
    neg_b = sgn_q && b_q[WIDTH-1];
    prod  = {hi_raw, lo_raw};
    fx_hi = hi_raw;
    fx_lo = lo_raw;
    if ((func_q == F_DIV) || (func_q == F_DIVU)) begin
      if (b_q == '0) begin
        fx_lo = '1;
        fx_hi = a_q;
      end else begin
        fx_lo = (neg_a ^ neg_b) ? -lo_raw : lo_raw;
        fx_hi = neg_a ? -hi_raw : hi_raw;
      end
    end else if (neg_a ^ neg_b) begin
      prod  = -prod;
      fx_hi = prod[2*WIDTH-1:WIDTH];
      fx_lo = prod[WIDTH-1:0];
    end
  end

  // Single-cycle datapath, evaluated on latched operands in DONE.
  logic [WIDTH-1:0] sum_add, diff, clz_src, sc_res;
  logic [SHW-1:0]   shamt;
  logic [SHW:0]     lz;
  logic             sc_z, sc_z_upd, sc_res_upd;

  always_comb begin
    clz_src = (func_q == F_CLO) ? ~a_q : a_q;
    lz      = (SHW+1)'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (clz_src[i]) lz = (SHW+1)'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    sum_add    = a_q + b_q;
    diff       = a_q - b_q;
    shamt      = b_q[SHW-1:0];
    sc_res     = '0;
    sc_z       = 1'b0;
    sc_z_upd   = 1'b0;
    sc_res_upd = 1'b1;
    case (func_q)
      F_AND:          sc_res = a_q & b_q;
      F_OR:           sc_res = a_q | b_q;
      F_XOR:          sc_res = a_q ^ b_q;
      F_NOR:          sc_res = ~(a_q | b_q);
      F_ADDU:         sc_res = sum_add;
      F_SUBU:         sc_res = diff;
      F_ADD: begin
        sc_res   = sum_add;
        sc_z     = (sum_add == '0);
        sc_z_upd = 1'b1;
      end
      F_SUB: begin
        sc_res   = diff;
        sc_z     = (diff == '0);
        sc_z_upd = 1'b1;
      end
      F_SLT:          sc_res = WIDTH'($signed(a_q) < $signed(b_q));
      F_SLTU:         sc_res = WIDTH'(a_q < b_q);
      F_SLL, F_SLLV:  sc_res = a_q << shamt;
      F_SRL, F_SRLV:  sc_res = a_q >> shamt;
      F_SRA:          sc_res = WIDTH'($signed(a_q) >>> shamt);
      F_CLO, F_CLZ:   sc_res = WIDTH'(lz);
      F_MFHI:         sc_res = hi;
      F_MFLO:         sc_res = lo;
      F_BGTZ: begin
        sc_z     = !a_q[WIDTH-1] && (a_q != '0);
        sc_z_upd = 1'b1;
      end
      F_BLEZ: begin
        sc_z     = a_q[WIDTH-1] || (a_q == '0);
        sc_z_upd = 1'b1;
      end
      F_B: begin
        sc_z     = 1'b1;
        sc_z_upd = 1'b1;
      end
      F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: sc_res_upd = 1'b0;
      default:        sc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      func_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      fix_hi <= '0;
      fix_lo <= '0;
      result <= '0;
      z_flag <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      if (accept) begin
        func_q <= func;
        a_q    <= a;
        b_q    <= b;
        cnt    <= '0;
        busy   <= 1'b1;
      end
      if (state == S_ITER) cnt <= cnt + 1'b1;
      if (state == S_FIX) begin
        fix_hi <= fx_hi;
        fix_lo <= fx_lo;
      end
      if (state == S_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
        if (func_class(func_q) == FC_MULTI) begin
          hi <= fix_hi;
          lo <= fix_lo;
        end else begin
          if (sc_res_upd)        result <= sc_res;
          if (sc_z_upd)          z_flag <= sc_z;
          if (func_q == F_MTHI)  hi     <= a_q;
          if (func_q == F_MTLO)  lo     <= a_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_hilo.sv
// Directed-vector bench: issued ops push hand-computed expectations into a
// scoreboard queue; a monitor pops and compares on every done pulse.
module tb_alu_seq_hilo;

  localparam logic [5:0] SLL = 6'b000000, SRL = 6'b000010, SRA = 6'b000011;
  localparam logic [5:0] SLLV = 6'b000100, SRLV = 6'b000110, CLZ = 6'b000111;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] ADD = 6'b100000, ADDU = 6'b100001, SUB = 6'b100010, SUBU = 6'b100011;
  localparam logic [5:0] AND_ = 6'b100100, OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111;
  localparam logic [5:0] SLT = 6'b101010, SLTU = 6'b101011;
  localparam logic [5:0] BGTZ = 6'b110010, BR = 6'b110100, BLEZ = 6'b110110, CLO = 6'b111000;
  localparam logic [5:0] UNK = 6'b111111;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  func;
  logic [31:0] a, b, result, hi, lo;
  logic        z_flag, done, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  alu_seq_hilo #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .func   (func),
    .a      (a),
    .b      (b),
    .result (result),
    .z_flag (z_flag),
    .done   (done),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".result"}, result, e.res);
        chk({e.name, ".z_flag"}, z_flag, e.z);
        chk({e.name, ".hi"}, hi, e.hi);
        chk({e.name, ".lo"}, lo, e.lo);
        chk({e.name, ".latency"}, cyc - e.acc_cyc - 1, e.lat);
      end
    end
  end

  task automatic op(input string nm, input logic [5:0] f, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] er, input logic ez,
                    input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk({nm, ".idle_wait"}, 64'd1, 64'd0);
    e.name    = nm;
    e.res     = er;
    e.z       = ez;
    e.hi      = eh;
    e.lo      = el;
    e.lat     = (f == MULT || f == MULTU || f == DIV || f == DIVU) ? 34 : 1;
    e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b1;
    func  = f;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    func  = 6'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int busy_low;
    int n_done;
    int guard;
    reset = 1'b1;
    start = 1'b0;
    func  = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst.result", result, 0);
    chk("rst.z_flag", z_flag, 0);
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    reset = 1'b0;

    // MULT with busy watch and an ignored start during iteration 5.
    op("mult_neg3x5", MULT, 32'hFFFFFFFD, 32'd5, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    busy_low = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      if (i == 4) begin
        start = 1'b1;
        func  = MTHI;
        a     = 32'h00001111;
      end
      if (i == 5) start = 1'b0;
    end
    chk("mult.busy_throughout", busy_low, 0);

    op("divu_100_7",    DIVU, 32'd100,      32'd7,        32'h0, 1'b0, 32'd2,        32'd14);
    op("div_m7_2",      DIV,  32'hFFFFFFF9, 32'd2,        32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op("divu_by0",      DIVU, 32'h1234,     32'd0,        32'h0, 1'b0, 32'h1234,     32'hFFFFFFFF);
    op("div_neg_by0",   DIV,  32'hFFFFFFF9, 32'd0,        32'h0, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    op("div_min_m1",    DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0,        32'h80000000);
    op("multu_max",     MULTU,32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'hFFFFFFFE, 32'h1);
    op("div_7_m2",      DIV,  32'd7,        32'hFFFFFFFE, 32'h0, 1'b0, 32'h1,        32'hFFFFFFFD);

    op("clz_0",         CLZ,  32'h0,        32'h0,  32'd32,       1'b0, 32'h1, 32'hFFFFFFFD);
    op("clo_ones",      CLO,  32'hFFFFFFFF, 32'h0,  32'd32,       1'b0, 32'h1, 32'hFFFFFFFD);
    op("clz_bit16",     CLZ,  32'h00010000, 32'h0,  32'd15,       1'b0, 32'h1, 32'hFFFFFFFD);
    op("clo_f0",        CLO,  32'hF0000000, 32'h0,  32'd4,        1'b0, 32'h1, 32'hFFFFFFFD);
    op("sra_24",        SRA,  32'h80000000, 32'd24, 32'hFFFFFF80, 1'b0, 32'h1, 32'hFFFFFFFD);
    op("sra_38",        SRA,  32'h80000000, 32'h38, 32'hFFFFFF80, 1'b0, 32'h1, 32'hFFFFFFFD);
    op("srl_4",         SRL,  32'h80000000, 32'd4,  32'h08000000, 1'b0, 32'h1, 32'hFFFFFFFD);
    op("sllv_31",       SLLV, 32'h1,        32'd31, 32'h80000000, 1'b0, 32'h1, 32'hFFFFFFFD);
    op("sll_wrap",      SLL,  32'h3,        32'h21, 32'h6,        1'b0, 32'h1, 32'hFFFFFFFD);
    op("srlv_4",        SRLV, 32'hF0,       32'd4,  32'hF,        1'b0, 32'h1, 32'hFFFFFFFD);

    op("add_zero",      ADD,  32'd5,        32'hFFFFFFFB, 32'h0,    1'b1, 32'h1, 32'hFFFFFFFD);
    op("and_holds_z",   AND_, 32'hF0F0,     32'hFF00,     32'hF000, 1'b1, 32'h1, 32'hFFFFFFFD);
    op("blez_min",      BLEZ, 32'h80000000, 32'h0,        32'h0,    1'b1, 32'h1, 32'hFFFFFFFD);
    op("bgtz_min",      BGTZ, 32'h80000000, 32'h0,        32'h0,    1'b0, 32'h1, 32'hFFFFFFFD);
    op("bgtz_1",        BGTZ, 32'h1,        32'h0,        32'h0,    1'b1, 32'h1, 32'hFFFFFFFD);
    op("blez_1",        BLEZ, 32'h1,        32'h0,        32'h0,    1'b0, 32'h1, 32'hFFFFFFFD);
    op("b_always",      BR,   32'h0,        32'h0,        32'h0,    1'b1, 32'h1, 32'hFFFFFFFD);
    op("sub_5_3",       SUB,  32'd5,        32'd3,        32'd2,    1'b0, 32'h1, 32'hFFFFFFFD);
    op("sub_7_7",       SUB,  32'd7,        32'd7,        32'h0,    1'b1, 32'h1, 32'hFFFFFFFD);
    op("addu_wrap",     ADDU, 32'hFFFFFFFF, 32'd1,        32'h0,    1'b1, 32'h1, 32'hFFFFFFFD);
    op("subu_wrap",     SUBU, 32'h0,        32'd1,        32'hFFFFFFFF, 1'b1, 32'h1, 32'hFFFFFFFD);
    op("add_ovf",       ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 32'h1, 32'hFFFFFFFD);
    op("slt_signed",    SLT,  32'hFFFFFFFF, 32'd1,        32'h1,    1'b0, 32'h1, 32'hFFFFFFFD);
    op("sltu_unsigned", SLTU, 32'hFFFFFFFF, 32'd1,        32'h0,    1'b0, 32'h1, 32'hFFFFFFFD);
    op("or",            OR_,  32'h0F,       32'hF0,       32'hFF,   1'b0, 32'h1, 32'hFFFFFFFD);
    op("xor",           XOR_, 32'hFF,       32'h0F,       32'hF0,   1'b0, 32'h1, 32'hFFFFFFFD);
    op("nor",           NOR_, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'h1, 32'hFFFFFFFD);

    op("mthi",          MTHI, 32'hCAFE,     32'h0,        32'hFFFFFFFF, 1'b0, 32'hCAFE, 32'hFFFFFFFD);
    op("mfhi",          MFHI, 32'h0,        32'h0,        32'hCAFE, 1'b0, 32'hCAFE, 32'hFFFFFFFD);
    op("mtlo",          MTLO, 32'hBEEF,     32'h0,        32'hCAFE, 1'b0, 32'hCAFE, 32'hBEEF);
    op("mflo",          MFLO, 32'h0,        32'h0,        32'hBEEF, 1'b0, 32'hCAFE, 32'hBEEF);
    op("unknown",       UNK,  32'h1234,     32'h5678,     32'h0,    1'b0, 32'hCAFE, 32'hBEEF);
    op("mult_m1x2",     MULT, 32'hFFFFFFFF, 32'd2,        32'h0,    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op("b_set",         BR,   32'h0,        32'h0,        32'h0,    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op("mflo_prod",     MFLO, 32'h0,        32'h0,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    // Reset in the middle of a DIV: no completion, HI/LO cleared.
    @(negedge clk);
    start = 1'b1;
    func  = DIV;
    a     = 32'd100;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.hi", hi, 0);
    chk("midrst.lo", lo, 0);
    chk("midrst.result", result, 0);
    chk("midrst.z_flag", z_flag, 0);
    reset  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("midrst.no_done_after", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
